// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers.
package aes_pkg;

  localparam int AES_BYTES   = 16;
  localparam int AES_STATE_W = AES_BYTES * 8;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // AddRoundKey: plain bitwise XOR, no byte reordering.
  function automatic aes_state_t add_key(input aes_state_t state, input aes_state_t key);
    return state ^ key;
  endfunction

endpackage

// File: rtl/aes_skid_buffer.sv
// Generic-width valid/ready output stage. SKID_EN=1 gives a 2-entry skid
// buffer with in_ready straight from a flop; SKID_EN=0 gives a single
// register with in_ready derived from out_ready.
module aes_skid_buffer
  import aes_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o
);

  if (SKID_EN) begin : g_skid
    occ_e              occ_q;
    logic              rdy_q;
    logic              vld_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              xfer;

    assign accept = in_valid_i && rdy_q;
    assign xfer   = vld_q && out_ready_i;

    // Occupancy FSM; ready/valid are kept as their own flops so in_ready
    // has no combinational dependence on out_ready.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        occ_q  <= OCC_EMPTY;
        rdy_q  <= 1'b1;
        vld_q  <= 1'b0;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        case (occ_q)
          OCC_EMPTY: begin
            if (accept) begin
              main_q <= data_i;
              vld_q  <= 1'b1;
              occ_q  <= OCC_ONE;
            end
          end
          OCC_ONE: begin
            if (accept && !xfer) begin
              skid_q <= data_i;
              rdy_q  <= 1'b0;
              occ_q  <= OCC_TWO;
            end else if (accept && xfer) begin
              main_q <= data_i;
            end else if (xfer) begin
              vld_q  <= 1'b0;
              occ_q  <= OCC_EMPTY;
            end
          end
          OCC_TWO: begin
            if (xfer) begin
              main_q <= skid_q;
              rdy_q  <= 1'b1;
              occ_q  <= OCC_ONE;
            end
          end
          default: begin
            occ_q <= OCC_EMPTY;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
          end
        endcase
      end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = vld_q;
    assign data_o      = main_q;
  end else begin : g_single
    logic              vld_q;
    logic [DATA_W-1:0] main_q;
    logic              rdy;

    assign rdy = !vld_q || out_ready_i;

    // Single output register: load on accept, clear valid once drained.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        main_q <= '0;
      end else if (in_valid_i && rdy) begin
        vld_q  <= 1'b1;
        main_q <= data_i;
      end else if (out_ready_i) begin
        vld_q  <= 1'b0;
      end
    end

    assign in_ready_o  = rdy;
    assign out_valid_o = vld_q;
    assign data_o      = main_q;
  end

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey stage: XOR state with round key, registered through a
// valid/ready output buffer. Results, not operands, are stored.
module add_round_key
  import aes_pkg::*;
#(
  parameter bit SKID_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t state_in,
  input  aes_state_t key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t state_out
);

  aes_state_t sum;

  assign sum = add_key(state_in, key_in);

  aes_skid_buffer #(
    .DATA_W (AES_STATE_W),
    .SKID_EN(SKID_EN)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .data_i     (sum),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .data_o     (state_out)
  );

endmodule

// File: tb/tb_add_round_key.sv
// Directed and random bench for add_round_key, both buffer modes side by side.
module tb_add_round_key;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv1, ir1, ov1, or1;
  aes_state_t s1, k1, o1;
  logic       iv0, ir0, ov0, or0;
  aes_state_t s0, k0, o0;

  add_round_key #(.SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .state_in(s1), .key_in(k1), .out_valid(ov1), .out_ready(or1), .state_out(o1)
  );

  add_round_key #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .state_in(s0), .key_in(k0), .out_valid(ov0), .out_ready(or0), .state_out(o0)
  );

  aes_state_t q1[$];
  aes_state_t q0[$];
  int checks = 0, passes = 0, fails = 0;
  int acc1_cnt = 0, out1_cnt = 0, out0_cnt = 0, push1 = 0, push0 = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic aes_state_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare both DUTs against the reference queues after inputs settle.
  task automatic check_all();
    #1;
    chk("ir1", ir1, 128'(q1.size() < 2));
    chk("ov1", ov1, 128'(q1.size() > 0));
    if (q1.size() > 0) chk("so1", o1, q1[0]);
    chk("ir0", ir0, 128'((q0.size() == 0) || or0));
    chk("ov0", ov0, 128'(q0.size() > 0));
    if (q0.size() > 0) chk("so0", o0, q0[0]);
  endtask

  // Advance one clock and update the reference model with the handshakes.
  task automatic tick();
    bit a1, x1, a0, x0, rst_act;
    aes_state_t v1, v0;
    a1 = iv1 && (q1.size() < 2);
    x1 = or1 && (q1.size() > 0);
    a0 = iv0 && ((q0.size() == 0) || or0);
    x0 = or0 && (q0.size() > 0);
    rst_act = !rst_n;
    if (iv1 && ir1) acc1_cnt++;
    v1 = s1 ^ k1;
    v0 = s0 ^ k0;
    @(posedge clk);
    #1;
    if (rst_act) begin
      q1.delete();
      q0.delete();
    end else begin
      if (x1) begin void'(q1.pop_front()); out1_cnt++; end
      if (a1) begin q1.push_back(v1); push1++; end
      if (x0) begin void'(q0.pop_front()); out0_cnt++; end
      if (a0) begin q0.push_back(v0); push0++; end
    end
  endtask

  initial begin
    aes_state_t sv, held;
    int base, acc_base, cyc;

    rst_n = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; s1 = '0; k1 = '0;
    iv0 = 1'b0; or0 = 1'b0; s0 = '0; k0 = '0;
    tick();
    tick();
    chk("rst_ov1", ov1, 0);
    chk("rst_so1", o1, 0);
    chk("rst_ov0", ov0, 0);
    chk("rst_so0", o0, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ir1", ir1, 1);
    chk("rst_ir0", ir0, 1);

    // Known-answer single beat
    s1 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    k1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    iv1 = 1'b1; or1 = 1'b1;
    check_all();
    tick();
    iv1 = 1'b0;
    chk("kat_vld", ov1, 1);
    chk("kat", o1, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
    check_all();
    tick();
    chk("kat_done", ov1, 0);
    check_all();

    // Identities
    sv = rnd128();
    s1 = sv; k1 = '0; iv1 = 1'b1;
    check_all();
    tick();
    chk("id_zero", o1, sv);
    s1 = sv; k1 = sv;
    check_all();
    tick();
    chk("id_self", o1, 128'h0);
    s1 = sv; k1 = '1;
    check_all();
    tick();
    chk("id_ones", o1, ~sv);
    iv1 = 1'b0;
    check_all();
    tick();
    check_all();

    // Streaming 100 beats at full rate
    base = out1_cnt;
    for (int i = 0; i < 100; i++) begin
      s1 = rnd128(); k1 = rnd128(); iv1 = 1'b1; or1 = 1'b1;
      check_all();
      if (i > 0) chk("stream_vld", ov1, 1);
      tick();
    end
    iv1 = 1'b0;
    check_all();
    tick();
    check_all();
    chk("stream_cnt", out1_cnt - base, 100);

    // Backpressure: out_ready low for 5 cycles with input always valid
    or1 = 1'b0;
    acc_base = acc1_cnt;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      s1 = rnd128(); k1 = rnd128(); iv1 = 1'b1;
      check_all();
      tick();
      if (i == 0) held = q1[0];
      else chk("bp_stable", o1, held);
    end
    chk("bp_acc", acc1_cnt - acc_base, 2);
    chk("bp_ir", ir1, 0);
    iv1 = 1'b0; or1 = 1'b1;
    check_all();
    chk("bp_first", o1, held);
    tick();
    check_all();
    tick();
    check_all();
    chk("bp_drained", ov1, 0);

    // Random valid/ready, 1000 beats through each mode
    push1 = 0; push0 = 0; out1_cnt = 0; out0_cnt = 0;
    cyc = 0;
    while ((out1_cnt < 1000 || out0_cnt < 1000) && cyc < 20000) begin
      iv1 = (push1 < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      iv0 = (push0 < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      or1 = 1'($urandom_range(0, 1));
      or0 = 1'($urandom_range(0, 1));
      s1 = rnd128(); k1 = rnd128();
      s0 = rnd128(); k0 = rnd128();
      check_all();
      tick();
      cyc++;
    end
    iv1 = 1'b0; iv0 = 1'b0; or1 = 1'b0; or0 = 1'b0;
    chk("rand_out1", out1_cnt, 1000);
    chk("rand_out0", out0_cnt, 1000);
    chk("rand_push1", push1, 1000);
    chk("rand_push0", push0, 1000);
    check_all();

    // Reset with beats held
    iv1 = 1'b1; or1 = 1'b0;
    s1 = rnd128(); k1 = rnd128();
    iv0 = 1'b1; or0 = 1'b0;
    s0 = rnd128(); k0 = rnd128();
    check_all();
    tick();
    iv0 = 1'b0;
    s1 = rnd128(); k1 = rnd128();
    check_all();
    tick();
    iv1 = 1'b0;
    check_all();
    chk("pre_rst_ir1", ir1, 0);
    rst_n = 1'b0;
    check_all();
    tick();
    chk("mrst_ov1", ov1, 0);
    chk("mrst_so1", o1, 0);
    chk("mrst_ov0", ov0, 0);
    chk("mrst_so0", o0, 0);
    rst_n = 1'b1;
    or1 = 1'b1;
    s1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    k1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    iv1 = 1'b1;
    check_all();
    chk("mrst_ir1", ir1, 1);
    tick();
    iv1 = 1'b0;
    chk("post_rst_vld", ov1, 1);
    chk("post_rst_xor", o1, 128'h00102030_40506070_8090a0b0_c0d0e0f0);
    check_all();
    tick();
    check_all();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
